// File: rtl/sargantana_icache_pkg.sv
// Shared types and geometry for the 4-way instruction-cache replacement logic.
package sargantana_icache_pkg;

   localparam int unsigned ICACHE_N_WAY       = 4;
   localparam int unsigned ICACHE_N_WAY_CLOG2 = 2;
   localparam int unsigned ICACHE_DEPTH       = 64;
   localparam int unsigned ICACHE_IDX_BITS    = $clog2(ICACHE_DEPTH);

   // Tree PLRU bits: [0] root, [1] ways 0/1 leaf, [2] ways 2/3 leaf.
   typedef logic [2:0]              icache_plru_t;
   typedef logic [ICACHE_N_WAY-1:0] icache_way_oh_t;
   typedef logic [ICACHE_N_WAY_CLOG2-1:0] icache_way_idx_t;

   function automatic icache_way_oh_t lowest_set(input icache_way_oh_t v);
      return v & (~v + icache_way_oh_t'(1));
   endfunction

   function automatic icache_way_idx_t oh_to_idx(input icache_way_oh_t oh);
      icache_way_idx_t idx;
      idx = '0;
      for (int i = ICACHE_N_WAY - 1; i >= 0; i--) begin
         if (oh[i]) idx = icache_way_idx_t'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/sargantana_icache_replace_unit_if.sv
// Request/response bundle between the cache controller and the replace unit.
interface sargantana_icache_replace_unit_if;
   import sargantana_icache_pkg::*;

   logic                       flush_i;
   logic                       access_valid_i;
   logic [ICACHE_IDX_BITS-1:0] access_idx_i;
   icache_way_oh_t             access_way_i;
   logic                       victim_req_i;
   logic [ICACHE_IDX_BITS-1:0] victim_idx_i;
   icache_way_oh_t             valid_bits_i;
   logic                       victim_valid_o;
   icache_way_oh_t             victim_way_oh_o;
   icache_way_idx_t            victim_way_o;
   logic                       fill_valid_i;
   logic [ICACHE_IDX_BITS-1:0] fill_idx_i;
   icache_way_oh_t             fill_way_i;

   modport master (
      output flush_i, access_valid_i, access_idx_i, access_way_i,
             victim_req_i, victim_idx_i, valid_bits_i,
             fill_valid_i, fill_idx_i, fill_way_i,
      input  victim_valid_o, victim_way_oh_o, victim_way_o
   );

   modport slave (
      input  flush_i, access_valid_i, access_idx_i, access_way_i,
             victim_req_i, victim_idx_i, valid_bits_i,
             fill_valid_i, fill_idx_i, fill_way_i,
      output victim_valid_o, victim_way_oh_o, victim_way_o
   );

endinterface

// File: rtl/sargantana_icache_plru_tree.sv
// Combinational 4-way tree PLRU: MRU update of one set's state and its victim.
module sargantana_icache_plru_tree
   import sargantana_icache_pkg::*;
(
   input  icache_plru_t   state_i,
   input  icache_way_oh_t way_i,
   output icache_plru_t   state_o,
   output icache_way_oh_t victim_oh_o
);

   icache_way_oh_t way_lo;

   assign way_lo = lowest_set(way_i);

   // NOTE: state_o is assigned first so no path leaves it unassigned (no latch).
   always_comb begin
      state_o = state_i;
      if (way_lo[0]) begin
         state_o[0] = 1'b1;
         state_o[1] = 1'b1;
      end else if (way_lo[1]) begin
         state_o[0] = 1'b1;
         state_o[1] = 1'b0;
      end else if (way_lo[2]) begin
         state_o[0] = 1'b0;
         state_o[2] = 1'b1;
      end else if (way_lo[3]) begin
         state_o[0] = 1'b0;
         state_o[2] = 1'b0;
      end
   end

   always_comb begin
      if (!state_i[0]) victim_oh_o = state_i[1] ? 4'b0010 : 4'b0001;
      else             victim_oh_o = state_i[2] ? 4'b1000 : 4'b0100;
   end

endmodule

// File: rtl/sargantana_icache_replace_unit.sv
// Victim-way selector: lowest invalid way, else tree PLRU (or an LFSR pick when
// ICACHE_REPL_RANDOM_EN is defined). Result is registered, one cycle after request.
module sargantana_icache_replace_unit
   import sargantana_icache_pkg::*;
(
   input  logic                             clk_i,
   input  logic                             rst_i,
   sargantana_icache_replace_unit_if.slave  bus
);

   if (ICACHE_N_WAY != 4) begin : g_bad_way_count
      $error("sargantana_icache_replace_unit supports exactly 4 ways");
   end

   icache_way_oh_t  invalid_ways;
   icache_way_oh_t  free_oh;
   icache_way_oh_t  repl_oh;
   icache_way_oh_t  pick_oh;
   logic            take_req;
   logic            victim_valid_q;
   icache_way_oh_t  victim_oh_q;
   icache_way_idx_t victim_way_q;

   assign invalid_ways = ~bus.valid_bits_i;
   assign free_oh      = lowest_set(invalid_ways);
   assign pick_oh      = (|invalid_ways) ? free_oh : repl_oh;
   assign take_req     = bus.victim_req_i && !bus.flush_i;

`ifdef ICACHE_REPL_RANDOM_EN
   logic [7:0] lfsr_q;
   logic [7:0] lfsr_d;
   logic       unused_upd;

   assign lfsr_d     = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
   assign repl_oh    = icache_way_oh_t'(1) << lfsr_q[1:0];
   assign unused_upd = ^{bus.access_valid_i, bus.access_idx_i, bus.access_way_i,
                         bus.fill_valid_i, bus.fill_idx_i, bus.fill_way_i, bus.victim_idx_i};

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) lfsr_q <= 8'h01;
      else       lfsr_q <= lfsr_d;
   end
`else
   icache_plru_t   plru_q [ICACHE_DEPTH];
   icache_plru_t   acc_next;
   icache_plru_t   fill_base;
   icache_plru_t   fill_next;
   icache_plru_t   unused_rd_next;
   icache_way_oh_t unused_acc_victim;
   icache_way_oh_t unused_fill_victim;
   logic           acc_en;
   logic           fill_en;

   assign acc_en  = bus.access_valid_i && (|bus.access_way_i);
   assign fill_en = bus.fill_valid_i && (|bus.fill_way_i);

   // A fill to the set hit in the same cycle builds on the access-updated state.
   assign fill_base = (acc_en && bus.access_idx_i == bus.fill_idx_i) ? acc_next
                                                                      : plru_q[bus.fill_idx_i];

   sargantana_icache_plru_tree u_acc_tree (
      .state_i     (plru_q[bus.access_idx_i]),
      .way_i       (bus.access_way_i),
      .state_o     (acc_next),
      .victim_oh_o (unused_acc_victim)
   );

   sargantana_icache_plru_tree u_fill_tree (
      .state_i     (fill_base),
      .way_i       (bus.fill_way_i),
      .state_o     (fill_next),
      .victim_oh_o (unused_fill_victim)
   );

   sargantana_icache_plru_tree u_read_tree (
      .state_i     (plru_q[bus.victim_idx_i]),
      .way_i       ('0),
      .state_o     (unused_rd_next),
      .victim_oh_o (repl_oh)
   );

   // NOTE: the state array is reset because a defined 3'b000 per set is observable.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < ICACHE_DEPTH; i++) plru_q[i] <= '0;
      end else if (bus.flush_i) begin
         for (int i = 0; i < ICACHE_DEPTH; i++) plru_q[i] <= '0;
      end else begin
         if (acc_en)  plru_q[bus.access_idx_i] <= acc_next;
         if (fill_en) plru_q[bus.fill_idx_i]   <= fill_next;
      end
   end
`endif

   // NOTE: non-blocking assignments keep every register sampling pre-edge values.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         victim_valid_q <= 1'b0;
         victim_oh_q    <= 4'b0001;
         victim_way_q   <= '0;
      end else begin
         victim_valid_q <= take_req;
         if (take_req) begin
            victim_oh_q  <= pick_oh;
            victim_way_q <= oh_to_idx(pick_oh);
         end
      end
   end

   assign bus.victim_valid_o  = victim_valid_q;
   assign bus.victim_way_oh_o = victim_oh_q;
   assign bus.victim_way_o    = victim_way_q;

   a_access_onehot: assert property (@(posedge clk_i) disable iff (rst_i)
      bus.access_valid_i |-> $onehot0(bus.access_way_i));
   a_fill_onehot: assert property (@(posedge clk_i) disable iff (rst_i)
      bus.fill_valid_i |-> $onehot0(bus.fill_way_i));

endmodule

// File: tb/tb_sargantana_icache_replace_unit.sv
// Directed bench for the icache victim selector; covers the random build when
// ICACHE_REPL_RANDOM_EN is defined.
module tb_sargantana_icache_replace_unit;
   import sargantana_icache_pkg::*;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   sargantana_icache_replace_unit_if bus ();

   sargantana_icache_replace_unit dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

`ifdef ICACHE_REPL_RANDOM_EN
   logic [7:0] lfsr_m;
   always @(posedge clk or posedge rst) begin
      if (rst) lfsr_m <= 8'h01;
      else     lfsr_m <= {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
   end
`endif

   function automatic logic [6:0] obs();
      return {bus.victim_valid_o, bus.victim_way_oh_o, bus.victim_way_o};
   endfunction

   function automatic logic [6:0] hit(input logic [1:0] way);
      return {1'b1, 4'b0001 << way, way};
   endfunction

   task automatic idle();
      bus.flush_i        = 1'b0;
      bus.access_valid_i = 1'b0;
      bus.access_idx_i   = '0;
      bus.access_way_i   = '0;
      bus.victim_req_i   = 1'b0;
      bus.victim_idx_i   = '0;
      bus.valid_bits_i   = 4'b1111;
      bus.fill_valid_i   = 1'b0;
      bus.fill_idx_i     = '0;
      bus.fill_way_i     = '0;
   endtask

   // Drives one request cycle; the result is visible on return.
   task automatic request(input logic [5:0] idx, input logic [3:0] vb);
      @(negedge clk);
      bus.victim_req_i = 1'b1;
      bus.victim_idx_i = idx;
      bus.valid_bits_i = vb;
      @(negedge clk);
      idle();
   endtask

   task automatic fill(input logic [5:0] idx, input logic [3:0] way);
      @(negedge clk);
      bus.fill_valid_i = 1'b1;
      bus.fill_idx_i   = idx;
      bus.fill_way_i   = way;
      @(negedge clk);
      idle();
   endtask

   task automatic test_reset();
      logic [6:0] got;
      rst = 1'b1;
      idle();
      #12;
      got = obs();
      checks++;
      if (got !== 7'b0_0001_00) begin
         errors++;
         $display("FAIL reset_during got=%b want=%b", got, 7'b0_0001_00);
      end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      got = obs();
      checks++;
      if (got !== 7'b0_0001_00) begin
         errors++;
         $display("FAIL reset_after got=%b want=%b", got, 7'b0_0001_00);
      end
   endtask

   task automatic test_reset_mid();
      logic [6:0] got;
      @(negedge clk);
      bus.victim_req_i = 1'b1;
      bus.victim_idx_i = 6'd2;
      bus.valid_bits_i = 4'b0111;
      @(posedge clk);
      #1;
      got = obs();
      checks++;
      if (got !== hit(2'd3)) begin
         errors++;
         $display("FAIL mid_reset_pre got=%b want=%b", got, hit(2'd3));
      end
      rst = 1'b1;
      idle();
      #1;
      got = obs();
      checks++;
      if (got !== 7'b0_0001_00) begin
         errors++;
         $display("FAIL mid_reset_drop got=%b want=%b", got, 7'b0_0001_00);
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_invalid_priority();
      logic [6:0] got;
      logic [5:0] idx [4] = '{6'd5, 6'd3, 6'd4, 6'd6};
      logic [3:0] vb  [4] = '{4'b0000, 4'b1011, 4'b1110, 4'b0111};
      logic [1:0] way [4] = '{2'd0, 2'd2, 2'd0, 2'd3};
      for (int i = 0; i < 4; i++) begin
         request(idx[i], vb[i]);
         got = obs();
         checks++;
         if (got !== hit(way[i])) begin
            errors++;
            $display("FAIL invalid_prio_%0d got=%b want=%b", i, got, hit(way[i]));
         end
      end
      @(negedge clk);
      got = obs();
      checks++;
      if (got !== {1'b0, 4'b1000, 2'd3}) begin
         errors++;
         $display("FAIL hold_after_result got=%b want=%b", got, {1'b0, 4'b1000, 2'd3});
      end
   endtask

   task automatic test_back_to_back();
      logic [6:0] got;
      @(negedge clk);
      bus.victim_req_i = 1'b1;
      bus.victim_idx_i = 6'd5;
      bus.valid_bits_i = 4'b0111;
      @(negedge clk);
      bus.valid_bits_i = 4'b1101;
      got = obs();
      checks++;
      if (got !== hit(2'd3)) begin
         errors++;
         $display("FAIL b2b_first got=%b want=%b", got, hit(2'd3));
      end
      @(negedge clk);
      idle();
      got = obs();
      checks++;
      if (got !== hit(2'd1)) begin
         errors++;
         $display("FAIL b2b_second got=%b want=%b", got, hit(2'd1));
      end
   endtask

`ifndef ICACHE_REPL_RANDOM_EN
   task automatic test_plru_fill_seq();
      logic [6:0] got;
      logic [3:0] fway [3] = '{4'b0001, 4'b0100, 4'b0010};
      logic [1:0] want [4] = '{2'd0, 2'd2, 2'd1, 2'd3};
      for (int i = 0; i < 4; i++) begin
         if (i > 0) fill(6'd7, fway[i-1]);
         request(6'd7, 4'b1111);
         got = obs();
         checks++;
         if (got !== hit(want[i])) begin
            errors++;
            $display("FAIL plru_seq_%0d got=%b want=%b", i, got, hit(want[i]));
         end
      end
   endtask

   task automatic test_same_cycle();
      logic [6:0] got;
      // Same set: access way3 then fill way1 -> b0=1 (fill), b1=0, b2=0 -> way2.
      @(negedge clk);
      bus.access_valid_i = 1'b1;
      bus.access_idx_i   = 6'd9;
      bus.access_way_i   = 4'b1000;
      bus.fill_valid_i   = 1'b1;
      bus.fill_idx_i     = 6'd9;
      bus.fill_way_i     = 4'b0010;
      @(negedge clk);
      idle();
      request(6'd9, 4'b1111);
      got = obs();
      checks++;
      if (got !== hit(2'd2)) begin
         errors++;
         $display("FAIL same_set_fill_wins got=%b want=%b", got, hit(2'd2));
      end
      // Different sets: access idx12 way1, fill idx13 way0, both applied.
      @(negedge clk);
      bus.access_valid_i = 1'b1;
      bus.access_idx_i   = 6'd12;
      bus.access_way_i   = 4'b0010;
      bus.fill_valid_i   = 1'b1;
      bus.fill_idx_i     = 6'd13;
      bus.fill_way_i     = 4'b0001;
      @(negedge clk);
      idle();
      request(6'd12, 4'b1111);
      got = obs();
      checks++;
      if (got !== hit(2'd2)) begin
         errors++;
         $display("FAIL diff_set_access got=%b want=%b", got, hit(2'd2));
      end
      request(6'd13, 4'b1111);
      got = obs();
      checks++;
      if (got !== hit(2'd2)) begin
         errors++;
         $display("FAIL diff_set_fill got=%b want=%b", got, hit(2'd2));
      end
   endtask

   task automatic test_zero_strobe();
      logic [6:0] got;
      @(negedge clk);
      bus.fill_valid_i   = 1'b1;
      bus.fill_idx_i     = 6'd11;
      bus.fill_way_i     = 4'b0000;
      bus.access_valid_i = 1'b1;
      bus.access_idx_i   = 6'd11;
      bus.access_way_i   = 4'b0000;
      @(negedge clk);
      idle();
      request(6'd11, 4'b1111);
      got = obs();
      checks++;
      if (got !== hit(2'd0)) begin
         errors++;
         $display("FAIL zero_way_no_update got=%b want=%b", got, hit(2'd0));
      end
   endtask

   task automatic test_read_pre_update();
      logic [6:0] got;
      @(negedge clk);
      bus.victim_req_i = 1'b1;
      bus.victim_idx_i = 6'd14;
      bus.valid_bits_i = 4'b1111;
      bus.fill_valid_i = 1'b1;
      bus.fill_idx_i   = 6'd14;
      bus.fill_way_i   = 4'b0001;
      @(negedge clk);
      idle();
      got = obs();
      checks++;
      if (got !== hit(2'd0)) begin
         errors++;
         $display("FAIL read_pre_update got=%b want=%b", got, hit(2'd0));
      end
      request(6'd14, 4'b1111);
      got = obs();
      checks++;
      if (got !== hit(2'd2)) begin
         errors++;
         $display("FAIL read_post_update got=%b want=%b", got, hit(2'd2));
      end
   endtask
`endif

   task automatic test_flush();
      logic [6:0] got;
      logic [6:0] held;
      held = {1'b0, obs() & 6'h3f};
      // Flush with a request on idx 7 and a fill on idx 20 in the same cycle.
      @(negedge clk);
      bus.flush_i      = 1'b1;
      bus.victim_req_i = 1'b1;
      bus.victim_idx_i = 6'd7;
      bus.valid_bits_i = 4'b1111;
      bus.fill_valid_i = 1'b1;
      bus.fill_idx_i   = 6'd20;
      bus.fill_way_i   = 4'b0001;
      @(negedge clk);
      idle();
      got = obs();
      checks++;
      if (got !== held) begin
         errors++;
         $display("FAIL flush_drops_req got=%b want=%b", got, held);
      end
`ifndef ICACHE_REPL_RANDOM_EN
      request(6'd7, 4'b1111);
      got = obs();
      checks++;
      if (got !== hit(2'd0)) begin
         errors++;
         $display("FAIL flush_clears_state got=%b want=%b", got, hit(2'd0));
      end
      request(6'd20, 4'b1111);
      got = obs();
      checks++;
      if (got !== hit(2'd0)) begin
         errors++;
         $display("FAIL flush_beats_fill got=%b want=%b", got, hit(2'd0));
      end
`endif
   endtask

`ifdef ICACHE_REPL_RANDOM_EN
   task automatic test_random();
      logic [6:0] got;
      logic [1:0] want;
      @(negedge clk);
      rst = 1'b1;
      idle();
      @(negedge clk);
      rst = 1'b0;
      bus.victim_req_i = 1'b1;
      bus.victim_idx_i = 6'd7;
      bus.valid_bits_i = 4'b1111;
      want = lfsr_m[1:0];
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         got = obs();
         checks++;
         if (got !== hit(want)) begin
            errors++;
            $display("FAIL lfsr_victim_%0d got=%b want=%b", i, got, hit(want));
         end
         want = lfsr_m[1:0];
      end
      idle();
      request(6'd7, 4'b1101);
      got = obs();
      checks++;
      if (got !== hit(2'd1)) begin
         errors++;
         $display("FAIL random_invalid_prio got=%b want=%b", got, hit(2'd1));
      end
   endtask
`endif

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_reset_mid();
      test_invalid_priority();
      test_back_to_back();
`ifdef ICACHE_REPL_RANDOM_EN
      test_random();
`else
      test_plru_fill_seq();
      test_same_cycle();
      test_zero_strobe();
      test_read_pre_update();
`endif
      test_flush();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
